// File: rtl/probe_buffer_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : probe_arb_pkg
// Description : Shared state encoding and sizing constants for the probe
//               buffer arbiter and its round-robin picker.
// Revision    : 1.0 - initial release
// ============================================================================
package probe_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 64;
    localparam int DEF_TIMEOUT = 16;

    localparam int BEAT_CNT_W  = 32;
    localparam int ABORT_CNT_W = 16;
    // TIMEOUT is at most 255, so an 8-bit idle counter always suffices
    localparam int TMO_CNT_W   = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage : probe_arb_pkg
`default_nettype wire

// File: rtl/probe_buffer_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Round-robin picker: first asserted request at or above ptr,
//               wrapping, returned as a one-hot grant and a binary index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   index,
    output logic               valid
);

    localparam logic [PTR_W:0] c_num = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W:0] w_cand;

    // Walk offsets from the far end so the nearest hit to ptr wins last
    always_comb begin
        grant  = '0;
        index  = '0;
        valid  = 1'b0;
        w_cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, ptr} + (PTR_W+1)'(k);
            if (w_cand >= c_num) begin
                w_cand = w_cand - c_num;
            end
            if (req[w_cand[PTR_W-1:0]]) begin
                valid = 1'b1;
                index = w_cand[PTR_W-1:0];
            end
        end
        if (valid) begin
            grant[index] = 1'b1;
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/probe_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : probe_buffer_arbiter
// Description : Message-locking round-robin arbiter feeding the probe buffer
//               write port, with idle timeout abort and beat/abort counters.
// Revision    : 1.0 - initial release
// ============================================================================
module probe_buffer_arbiter
    import probe_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         probe_write,
    output logic                      probe_wen,
    output logic [BEAT_CNT_W-1:0]     beat_count,
    output logic [ABORT_CNT_W-1:0]    abort_count,
    output logic                      busy
);

    localparam int                    PTR_W      = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0]      c_last_idx = PTR_W'(NUM_REQ - 1);
    localparam logic [TMO_CNT_W-1:0]  c_tmo_last = TMO_CNT_W'(TIMEOUT - 1);

    function automatic logic [PTR_W-1:0] inc_idx(input logic [PTR_W-1:0] i);
        return (i == c_last_idx) ? '0 : i + 1'b1;
    endfunction

    arb_state_t             r_state, w_state_nxt;
    logic [PTR_W-1:0]       r_owner, w_owner_nxt;
    logic [PTR_W-1:0]       r_rr_ptr, w_rr_ptr_nxt;
    logic [TMO_CNT_W-1:0]   r_tmo, w_tmo_nxt;
    logic                   w_abort;

    logic [DATA_W-1:0]      r_probe_write;
    logic                   r_probe_wen;
    logic [BEAT_CNT_W-1:0]  r_beat_count;
    logic [ABORT_CNT_W-1:0] r_abort_count;

    logic [NUM_REQ-1:0]     w_pick_grant;
    logic [PTR_W-1:0]       w_pick_idx;
    logic                   w_pick_any;
    logic [NUM_REQ-1:0]     w_owner_oh;
    logic [PTR_W-1:0]       w_sel_idx;
    logic                   w_sel_last;
    logic [DATA_W-1:0]      w_sel_data;
    logic                   w_accept;
    logic [DATA_W-1:0]      w_data_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_pick_grant),
        .index (w_pick_idx),
        .valid (w_pick_any)
    );

    assign w_owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;

    // Ready never looks at data or last, so no path from those inputs exists
    always_comb begin
        req_ready = '0;
        if (reset && enable) begin
            if (r_state == LOCKED) begin
                req_ready = w_owner_oh;
            end else if (w_pick_any) begin
                req_ready = w_pick_grant;
            end
        end
    end

    assign w_accept   = |(req_ready & req_valid);
    assign w_sel_idx  = (r_state == LOCKED) ? r_owner : w_pick_idx;
    assign w_sel_last = req_last[w_sel_idx];
    assign w_sel_data = w_data_arr[w_sel_idx];

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        w_tmo_nxt    = r_tmo;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_sel_last) begin
                        w_rr_ptr_nxt = inc_idx(w_pick_idx);
                    end else begin
                        w_state_nxt = LOCKED;
                        w_owner_nxt = w_pick_idx;
                        w_tmo_nxt   = '0;
                    end
                end
            end
            LOCKED: begin
                if (enable) begin
                    if (w_accept) begin
                        // A beat on the threshold cycle wins over the abort
                        w_tmo_nxt = '0;
                        if (w_sel_last) begin
                            w_state_nxt  = IDLE;
                            w_rr_ptr_nxt = inc_idx(r_owner);
                        end
                    end else if (r_tmo == c_tmo_last) begin
                        w_abort      = 1'b1;
                        w_state_nxt  = IDLE;
                        w_rr_ptr_nxt = inc_idx(r_owner);
                        w_tmo_nxt    = '0;
                    end else begin
                        w_tmo_nxt = r_tmo + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_tmo    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_tmo    <= w_tmo_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_probe_write <= '0;
            r_probe_wen   <= 1'b0;
            r_beat_count  <= '0;
            r_abort_count <= '0;
        end else begin
            r_probe_wen <= w_accept;
            if (w_accept) begin
                r_probe_write <= w_sel_data;
                r_beat_count  <= r_beat_count + 1'b1;
            end
            if (w_abort && (r_abort_count != '1)) begin
                r_abort_count <= r_abort_count + 1'b1;
            end
        end
    end

    assign probe_write = r_probe_write;
    assign probe_wen   = r_probe_wen;
    assign beat_count  = r_beat_count;
    assign abort_count = r_abort_count;
    assign busy        = (r_state == LOCKED);

endmodule : probe_buffer_arbiter
`default_nettype wire

// File: tb/tb_probe_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_probe_buffer_arbiter
// Description : Directed and random stimulus against a message-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_probe_buffer_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 64;
    localparam int TMO = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            enable = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_last = '0;
    logic [DW-1:0]   din [NR];
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [DW-1:0]   probe_write;
    logic            probe_wen;
    logic [31:0]     beat_count;
    logic [15:0]     abort_count;
    logic            busy;

    assign req_data = {din[3], din[2], din[1], din[0]};

    probe_buffer_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .probe_write (probe_write),
        .probe_wen   (probe_wen),
        .beat_count  (beat_count),
        .abort_count (abort_count),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    logic [NR-1:0] obs_ready;

    // Message-level reference: who owns the port, whose turn is next,
    // how many idle cycles the current message has spent.
    bit          m_locked;
    int          m_owner;
    int          m_ptr;
    int          m_idle;
    bit          m_wen;
    logic [DW-1:0] m_write;
    int unsigned m_beats;
    int          m_aborts;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
        m_wen = 0; m_write = '0; m_beats = 0; m_aborts = 0;
    endtask

    function automatic logic [NR-1:0] mdl_ready();
        logic [NR-1:0] r;
        r = '0;
        if (!reset || !enable) return r;
        if (m_locked) begin
            r[m_owner] = 1'b1;
            return r;
        end
        for (int k = 0; k < NR; k++) begin
            if (req_valid[(m_ptr + k) % NR]) begin
                r[(m_ptr + k) % NR] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic mdl_clock(input logic [NR-1:0] rdy);
        int j;
        j = 0;
        m_wen = 0;
        if (!enable) return;
        if ((rdy & req_valid) != '0) begin
            for (int k = 0; k < NR; k++) if (rdy[k]) j = k;
            m_wen = 1;
            m_write = din[j];
            m_beats++;
            if (m_locked) begin
                m_idle = 0;
                if (req_last[j]) begin
                    m_locked = 0;
                    m_ptr = (j + 1) % NR;
                end
            end else if (req_last[j]) begin
                m_ptr = (j + 1) % NR;
            end else begin
                m_locked = 1;
                m_owner = j;
                m_idle = 0;
            end
        end else if (m_locked) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_locked = 0;
                m_ptr = (m_owner + 1) % NR;
                m_idle = 0;
                if (m_aborts < 65535) m_aborts++;
            end
        end
    endtask

    task automatic drive(input logic en, input logic [NR-1:0] v, input logic [NR-1:0] l);
        enable = en;
        req_valid = v;
        req_last = l;
        for (int i = 0; i < NR; i++) din[i] = {$urandom, $urandom};
    endtask

    task automatic cycle();
        logic [NR-1:0] exp_r;
        #1;
        exp_r = mdl_ready();
        obs_ready = req_ready;
        chk("req_ready", req_ready, exp_r);
        @(posedge clock);
        mdl_clock(exp_r);
        #1;
        chk("probe_wen", probe_wen, m_wen);
        chk("probe_write", probe_write, m_write);
        chk("beat_count", beat_count, m_beats);
        chk("abort_count", abort_count, m_aborts);
        chk("busy", busy, m_locked);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_wen"}, probe_wen, 0);
        chk({tag, "_write"}, probe_write, 0);
        chk({tag, "_beats"}, beat_count, 0);
        chk({tag, "_aborts"}, abort_count, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NR; i++) din[i] = '0;
        mdl_reset();
        enable = 1'b1;
        req_valid = 4'hF;
        req_last = 4'hF;
        #12;
        chk_reset_outputs("rst");
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Single-beat round robin across all four requesters
        for (int i = 0; i < 8; i++) begin
            drive(1, 4'hF, 4'hF);
            cycle();
            chk("rr_grant", obs_ready, 4'b0001 << (i % 4));
        end
        drive(1, 4'h0, 4'h0);
        cycle();
        chk("rr_beats", beat_count, 8);

        // Locked message from req1 while req0/req2 keep requesting
        drive(1, 4'b0111, 4'b0001); cycle();
        chk("lock_pre", obs_ready, 4'b0001);
        drive(1, 4'b0111, 4'b0000); cycle();
        chk("lock_b1", obs_ready, 4'b0010);
        drive(1, 4'b0111, 4'b0000); cycle();
        chk("lock_b2", obs_ready, 4'b0010);
        drive(1, 4'b0111, 4'b0010); cycle();
        chk("lock_b3", obs_ready, 4'b0010);
        drive(1, 4'b0111, 4'b0100); cycle();
        chk("lock_next", obs_ready, 4'b0100);

        // Timeout: req3 opens a message then goes silent
        drive(1, 4'b1000, 4'b0000); cycle();
        chk("tmo_grant", obs_ready, 4'b1000);
        drive(1, 4'h0, 4'h0);
        for (int i = 0; i < TMO; i++) begin
            cycle();
            chk("tmo_busy", busy, (i < TMO - 1));
        end
        chk("tmo_abort", abort_count, 1);

        // Beat arrives exactly on the threshold cycle
        drive(1, 4'b0100, 4'b0000); cycle();
        chk("coin_grant", obs_ready, 4'b0100);
        drive(1, 4'h0, 4'h0);
        for (int i = 0; i < TMO - 1; i++) cycle();
        drive(1, 4'b0100, 4'b0000); cycle();
        chk("coin_ready", obs_ready, 4'b0100);
        chk("coin_busy", busy, 1);
        chk("coin_abort", abort_count, 1);
        drive(1, 4'b0100, 4'b0100); cycle();

        // Enable low freezes the idle counter mid-message
        drive(1, 4'b0001, 4'b0000); cycle();
        chk("en_grant", obs_ready, 4'b0001);
        drive(1, 4'h0, 4'h0);
        for (int i = 0; i < 10; i++) cycle();
        for (int i = 0; i < 5; i++) begin
            drive(0, 4'b0001, 4'b0001);
            cycle();
            chk("en_off_ready", obs_ready, 0);
            chk("en_off_wen", probe_wen, 0);
        end
        drive(1, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) cycle();
        chk("en_still_busy", busy, 1);
        drive(1, 4'b0011, 4'b0001); cycle();
        chk("en_resume", obs_ready, 4'b0001);

        // Asynchronous reset in the middle of a locked message
        drive(1, 4'b0010, 4'b0000); cycle();
        drive(1, 4'b0010, 4'b0000); cycle();
        chk("pre_rst_busy", busy, 1);
        #3;
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        mdl_reset();
        @(posedge clock);
        #1;
        chk_reset_outputs("rst_hold");
        reset = 1'b1;
        drive(1, 4'hF, 4'hF); cycle();
        chk("post_rst_grant", obs_ready, 4'b0001);

        // Random traffic: dense then sparse valids to provoke timeouts
        for (int i = 0; i < 600; i++) begin
            logic [NR-1:0] v, l;
            v = ($urandom % 4 == 0) ? 4'h0 : NR'($urandom);
            l = '0;
            for (int b = 0; b < NR; b++) l[b] = ($urandom % 10) < 4;
            drive(($urandom % 10) != 0, v, l);
            cycle();
        end
        for (int i = 0; i < 600; i++) begin
            logic [NR-1:0] v, l;
            v = '0;
            l = '0;
            for (int b = 0; b < NR; b++) begin
                v[b] = ($urandom % 100) < 4;
                l[b] = ($urandom % 10) < 3;
            end
            drive(($urandom % 10) != 0, v, l);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_probe_buffer_arbiter
`default_nettype wire
